spi_slave: RTL and testbench

- SPI mode-0 slave (CPOL=0, CPHA=0), 8-bit frames, MSB first, full duplex.
- Oversamples the external SCK, SS and MOSI with the system clock.
- Receives one byte from MOSI and presents it on OUT; simultaneously returns the parallel byte on DATA via MISO.
- Sits between an external SPI master pin interface and on-chip register logic.

---
 rtl/spi_pkg.sv | 9 +
 rtl/spi_sync_edge.sv | 42 ++++
 rtl/spi_slave.sv | 107 ++++++++++
 tb/tb_spi_slave.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared constants for the SPI slave block.
// Frame width, synchronizer depth and idle MISO level.
package spi_pkg;

   localparam int unsigned SPI_WIDTH       = 8;
   localparam int unsigned SPI_SYNC_STAGES = 2;
   localparam logic        SPI_MISO_IDLE   = 1'b0;

endpackage

// File: rtl/spi_sync_edge.sv
// N-stage synchronizer with optional one-cycle rise/fall pulses.
// Ports: clk, rst (async active-low), d in; q, rise, fall out.
module spi_sync_edge #(
   parameter int unsigned STAGES  = 2,
   parameter logic        RST_VAL = 1'b0,
   parameter bit          EDGES   = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] chain;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) chain <= {STAGES{RST_VAL}};
      else      chain <= {chain[STAGES-2:0], d};
   end

   assign q = chain[STAGES-1];

   generate
      if (EDGES) begin : g_edge
         logic prev;

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) prev <= RST_VAL;
            else      prev <= q;
         end

         assign rise = q & ~prev;
         assign fall = ~q & prev;
      end else begin : g_no_edge
         assign rise = 1'b0;
         assign fall = 1'b0;
      end
   endgenerate

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 slave, oversampled by clk, MSB first, full duplex.
// Ports: clk, rst (async low), SCK, SS, MOSI, DATA in; MISO, OUT out.
module spi_slave
   import spi_pkg::*;
#(
   parameter int unsigned WIDTH       = SPI_WIDTH,
   parameter int unsigned SYNC_STAGES = SPI_SYNC_STAGES
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             SCK,
   input  logic             SS,
   input  logic             MOSI,
   output logic             MISO,
   input  logic [WIDTH-1:0] DATA,
   output logic [WIDTH-1:0] OUT
);

   localparam int unsigned    CW   = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   logic             sck_q, sck_rise, sck_fall;
   logic             ss_q, ss_rise, ss_fall;
   logic             mosi_q, mosi_rise, mosi_fall;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] rx_shift, tx_shift, rx_next;
   logic             unused_edges;

   spi_sync_edge #(
      .STAGES  (SYNC_STAGES),
      .RST_VAL (1'b0),
      .EDGES   (1'b1)
   ) u_sck (
      .clk  (clk),
      .rst  (rst),
      .d    (SCK),
      .q    (sck_q),
      .rise (sck_rise),
      .fall (sck_fall)
   );

   spi_sync_edge #(
      .STAGES  (SYNC_STAGES),
      .RST_VAL (1'b1),
      .EDGES   (1'b1)
   ) u_ss (
      .clk  (clk),
      .rst  (rst),
      .d    (SS),
      .q    (ss_q),
      .rise (ss_rise),
      .fall (ss_fall)
   );

   // Same depth as SCK so the sampled bit lines up with sck_rise.
   spi_sync_edge #(
      .STAGES  (SYNC_STAGES),
      .RST_VAL (1'b0),
      .EDGES   (1'b0)
   ) u_mosi (
      .clk  (clk),
      .rst  (rst),
      .d    (MOSI),
      .q    (mosi_q),
      .rise (mosi_rise),
      .fall (mosi_fall)
   );

   assign unused_edges = &{1'b0, sck_q, ss_rise, ss_fall,
                           mosi_rise, mosi_fall};

   assign rx_next = {rx_shift[WIDTH-2:0], mosi_q};

   // Synced SS high covers abort and SS-beats-sck_rise: the idle
   // branch wins, so partial bits never reach OUT.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         OUT      <= '0;
         cnt      <= '0;
         rx_shift <= '0;
         tx_shift <= '0;
      end else if (ss_q) begin
         cnt      <= '0;
         tx_shift <= DATA;
      end else begin
         if (sck_rise) begin
            rx_shift <= rx_next;
            if (cnt == LAST) begin
               OUT <= rx_next;
               cnt <= '0;
            end else begin
               cnt <= cnt + CW'(1);
            end
         end
         // cnt is 0 on a fall only right after a completed byte,
         // so that fall starts the next byte from DATA.
         if (sck_fall) begin
            if (cnt == '0) tx_shift <= DATA;
            else           tx_shift <= {tx_shift[WIDTH-2:0], 1'b0};
         end
      end
   end

   // Raw SS so the MSB is on the wire before the first SCK rise.
   assign MISO = SS ? SPI_MISO_IDLE : tx_shift[WIDTH-1];

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave acting as a mode-0 SPI master.
// Table-driven frames plus abort, reset and two-byte sequences.
module tb_spi_slave;

   logic       clk;
   logic       rst;
   logic       SCK;
   logic       SS;
   logic       MOSI;
   logic       MISO;
   logic [7:0] DATA;
   logic [7:0] OUT;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [7:0] mosi;
      logic [7:0] data;
      logic [7:0] exp_out;
      logic [7:0] exp_miso;
   } vec_t;

   vec_t vecs[3];

   spi_slave #(
      .WIDTH       (8),
      .SYNC_STAGES (2)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .SCK  (SCK),
      .SS   (SS),
      .MOSI (MOSI),
      .MISO (MISO),
      .DATA (DATA),
      .OUT  (OUT)
   );

   initial clk = 1'b0;
   always #50 clk = ~clk;

   task automatic check(input string name,
                        input logic [15:0] act,
                        input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One SCK period: MOSI set in the low phase, MISO taken late
   // in the high phase, then SCK falls.
   task automatic sck_cycle(input logic mbit, output logic sbit);
      MOSI = mbit;
      #200 SCK = 1'b1;
      #190 sbit = MISO;
      #10 SCK = 1'b0;
   endtask

   task automatic do_frame(input logic [7:0] mbyte,
                           input logic [7:0] dbyte,
                           output logic [7:0] got);
      logic b;
      DATA = dbyte;
      #350 SS = 1'b0;
      for (int i = 7; i >= 0; i--) begin
         sck_cycle(mbyte[i], b);
         got[i] = b;
      end
      #200 SS = 1'b1;
      #400;
   endtask

   initial begin
      logic [7:0]  got;
      logic [15:0] got16;
      logic [15:0] word;
      logic        b;

      vecs[0] = '{mosi: 8'hA5, data: 8'hB1, exp_out: 8'hA5, exp_miso: 8'hB1};
      vecs[1] = '{mosi: 8'h3C, data: 8'h1F, exp_out: 8'h3C, exp_miso: 8'h1F};
      vecs[2] = '{mosi: 8'hF0, data: 8'hEA, exp_out: 8'hF0, exp_miso: 8'hEA};

      rst  = 1'b0;
      SS   = 1'b1;
      SCK  = 1'b0;
      MOSI = 1'b0;
      DATA = 8'h00;
      #60;
      check("reset_out", {8'h0, OUT}, 16'h0000);
      check("reset_miso", {15'h0, MISO}, 16'h0000);
      #60 rst = 1'b1;
      #200;
      check("post_reset_out", {8'h0, OUT}, 16'h0000);
      check("post_reset_miso", {15'h0, MISO}, 16'h0000);

      foreach (vecs[k]) begin
         do_frame(vecs[k].mosi, vecs[k].data, got);
         check($sformatf("frame%0d_out", k), {8'h0, OUT},
               {8'h0, vecs[k].exp_out});
         check($sformatf("frame%0d_miso", k), {8'h0, got},
               {8'h0, vecs[k].exp_miso});
         check($sformatf("frame%0d_idle_miso", k), {15'h0, MISO},
               16'h0000);
         #200;
      end

      // Aborted frame: four bits of ones, then SS released.
      DATA = 8'h99;
      #350 SS = 1'b0;
      for (int i = 0; i < 4; i++) sck_cycle(1'b1, b);
      #200 SS = 1'b1;
      #400;
      check("abort_out", {8'h0, OUT}, 16'h00F0);
      check("abort_miso", {15'h0, MISO}, 16'h0000);
      do_frame(8'h5A, 8'hC3, got);
      check("after_abort_out", {8'h0, OUT}, 16'h005A);
      check("after_abort_miso", {8'h0, got}, 16'h00C3);

      // Reset asserted after three bits of a frame.
      DATA = 8'h55;
      #350 SS = 1'b0;
      for (int i = 0; i < 3; i++) sck_cycle(1'b1, b);
      rst = 1'b0;
      #10;
      check("midreset_out", {8'h0, OUT}, 16'h0000);
      SS = 1'b1;
      #100 rst = 1'b1;
      #300;
      do_frame(8'h81, 8'h7E, got);
      check("after_reset_out", {8'h0, OUT}, 16'h0081);
      check("after_reset_miso", {8'h0, got}, 16'h007E);

      // Two bytes under one SS; DATA switches before the 8th fall.
      word = 16'h1234;
      DATA = 8'hAB;
      #350 SS = 1'b0;
      for (int i = 0; i < 16; i++) begin
         MOSI = word[15-i];
         #200;
         if (i == 8) check("two_byte_out1", {8'h0, OUT}, 16'h0012);
         SCK = 1'b1;
         if (i == 7) begin
            #100 DATA = 8'hCD;
            #90;
         end else begin
            #190;
         end
         got16[15-i] = MISO;
         #10 SCK = 1'b0;
      end
      #200 SS = 1'b1;
      #400;
      check("two_byte_out2", {8'h0, OUT}, 16'h0034);
      check("two_byte_miso1", {8'h0, got16[15:8]}, 16'h00AB);
      check("two_byte_miso2", {8'h0, got16[7:0]}, 16'h00CD);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
